dmem_arbiter: RTL

- Two-requester arbiter and sequencer for the single-port data memory.
- Port 0 is the core load/store path; port 1 is the debug/DMA path.
- Latches one request at a time, drives the memory's address/data/MemRead/MemWrite/data_type controls, waits on the memory hit, then returns a registered response.
- Range-checks every access against the memory size; an out-of-range access is never forwarded to memory.

---
 rtl/dmem_arbiter.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer in front of the single-port data memory.
// Latency: accept in T, ACCESS in T+1, rvalid in T+2 on an immediate hit (one access per 3 cycles).
// Backpressure: one request in flight; ready pulses only in IDLE, and an ACCESS waits on mem_hit_i
// for up to WAIT_MAX cycles before it is aborted with an error.
//
// Ports:
//   clk_i, rst_n_i                    clock (rising edge), asynchronous active-low reset
//   reqN_valid/addr/wdata/we/type_i   request from port N (0 = core load/store, 1 = debug/DMA)
//   reqN_ready_o                      request accepted this cycle
//   reqN_rvalid/rdata/err_o           registered one-cycle response to port N
//   mem_*                             address/data/MemRead/MemWrite/data_type to memory, data/hit back
//
// Build option: define DMEM_ARB_RR_EN for round-robin arbitration on simultaneous valids;
// without it port 0 has fixed priority.

module dmem_arbiter #(
  parameter int unsigned MEM_BYTES = 2048,
  parameter int unsigned WAIT_MAX  = 15
) (
  input  logic        clk_i,
  input  logic        rst_n_i,

  input  logic        req0_valid_i,
  input  logic [31:0] req0_addr_i,
  input  logic [31:0] req0_wdata_i,
  input  logic        req0_we_i,
  input  logic [2:0]  req0_type_i,
  output logic        req0_ready_o,
  output logic        req0_rvalid_o,
  output logic [31:0] req0_rdata_o,
  output logic        req0_err_o,

  input  logic        req1_valid_i,
  input  logic [31:0] req1_addr_i,
  input  logic [31:0] req1_wdata_i,
  input  logic        req1_we_i,
  input  logic [2:0]  req1_type_i,
  output logic        req1_ready_o,
  output logic        req1_rvalid_o,
  output logic [31:0] req1_rdata_o,
  output logic        req1_err_o,

  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_wr_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [2:0]  mem_type_o,
  input  logic [31:0] mem_data_rd_i,
  input  logic        mem_hit_i
);

  // Memory data_type encoding.
  localparam logic [2:0] MEM_TYPE_INT8   = 3'd0;
  localparam logic [2:0] MEM_TYPE_INT16  = 3'd1;
  localparam logic [2:0] MEM_TYPE_INT32  = 3'd2;
  localparam logic [2:0] MEM_TYPE_UINT8  = 3'd3;
  localparam logic [2:0] MEM_TYPE_UINT16 = 3'd4;

  localparam int unsigned CNT_W = $clog2(WAIT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               req_we_q, req_we_d;
  logic               req_id_q, req_id_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [31:0]        mem_data_wr_q, mem_data_wr_d;
  logic [2:0]         mem_type_q, mem_type_d;
  logic               mem_read_q, mem_read_d;
  logic               mem_write_q, mem_write_d;
  logic               rvalid0_q, rvalid0_d;
  logic               rvalid1_q, rvalid1_d;
  logic               err0_q, err0_d;
  logic               err1_q, err1_d;
  logic [31:0]        rdata0_q, rdata0_d;
  logic [31:0]        rdata1_q, rdata1_d;
`ifdef DMEM_ARB_RR_EN
  // Port that wins the next simultaneous request.
  logic               prio_q, prio_d;
`endif

  // Winner selection and range check of the winning request.
  logic               any_vld;
  logic               win_id;
  logic [31:0]        win_addr;
  logic [31:0]        win_wdata;
  logic               win_we;
  logic [2:0]         win_type;
  logic [32:0]        win_size;
  logic [32:0]        win_end;
  logic               win_in_range;

  always_comb begin
    any_vld = req0_valid_i | req1_valid_i;
`ifdef DMEM_ARB_RR_EN
    win_id  = (req0_valid_i & req1_valid_i) ? prio_q : req1_valid_i;
`else
    win_id  = ~req0_valid_i;
`endif
    win_addr  = win_id ? req1_addr_i  : req0_addr_i;
    win_wdata = win_id ? req1_wdata_i : req0_wdata_i;
    win_we    = win_id ? req1_we_i    : req0_we_i;
    win_type  = win_id ? req1_type_i  : req0_type_i;

    case (win_type)
      MEM_TYPE_INT8, MEM_TYPE_UINT8:   win_size = 33'd1;
      MEM_TYPE_INT16, MEM_TYPE_UINT16: win_size = 33'd2;
      MEM_TYPE_INT32:                  win_size = 33'd4;
      default:                         win_size = 33'd4;
    endcase

    // 33-bit sum so an access near 0xFFFFFFFF cannot wrap into range.
    win_end      = {1'b0, win_addr} + win_size;
    win_in_range = (win_end <= 33'(MEM_BYTES));
  end

  // Ready is combinational so the requester sees it in the cycle it is latched.
  assign req0_ready_o = rst_n_i & (state_q == S_IDLE) & any_vld & ~win_id;
  assign req1_ready_o = rst_n_i & (state_q == S_IDLE) & any_vld &  win_id;

  // Next-state logic.
  logic        resp_set;
  logic        resp_err;
  logic [31:0] resp_data;
  logic        resp_id;

  always_comb begin
    state_d       = state_q;
    req_we_d      = req_we_q;
    req_id_d      = req_id_q;
    wait_cnt_d    = wait_cnt_q;
    mem_addr_d    = mem_addr_q;
    mem_data_wr_d = mem_data_wr_q;
    mem_type_d    = mem_type_q;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    resp_set      = 1'b0;
    resp_err      = 1'b0;
    resp_data     = 32'h0;
    resp_id       = req_id_q;
`ifdef DMEM_ARB_RR_EN
    prio_d        = prio_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (any_vld) begin
          req_we_d   = win_we;
          req_id_d   = win_id;
          wait_cnt_d = '0;
`ifdef DMEM_ARB_RR_EN
          prio_d     = ~win_id;
`endif
          if (win_in_range) begin
            state_d       = S_ACCESS;
            mem_addr_d    = win_addr;
            mem_data_wr_d = win_wdata;
            mem_type_d    = win_type;
            mem_read_d    = ~win_we;
            mem_write_d   = win_we;
          end else begin
            // Never forwarded: memory controls stay low and address holds.
            state_d  = S_RESP;
            resp_set = 1'b1;
            resp_err = 1'b1;
            resp_id  = win_id;
          end
        end
      end

      S_ACCESS: begin
        if (mem_hit_i) begin
          state_d   = S_RESP;
          resp_set  = 1'b1;
          resp_data = req_we_q ? 32'h0 : mem_data_rd_i;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
          if (wait_cnt_d == CNT_W'(WAIT_MAX)) begin
            state_d  = S_RESP;
            resp_set = 1'b1;
            resp_err = 1'b1;
          end else begin
            mem_read_d  = mem_read_q;
            mem_write_d = mem_write_q;
          end
        end
      end

      S_RESP: begin
        wait_cnt_d = '0;
        state_d    = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    rvalid0_d = resp_set & ~resp_id;
    rvalid1_d = resp_set &  resp_id;
    err0_d    = rvalid0_d & resp_err;
    err1_d    = rvalid1_d & resp_err;
    rdata0_d  = rvalid0_d ? resp_data : 32'h0;
    rdata1_d  = rvalid1_d ? resp_data : 32'h0;
  end

  // All state and outputs registered; the async reset drops mem_write_o immediately.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= S_IDLE;
      req_we_q      <= 1'b0;
      req_id_q      <= 1'b0;
      wait_cnt_q    <= '0;
      mem_addr_q    <= 32'h0;
      mem_data_wr_q <= 32'h0;
      mem_type_q    <= 3'd0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      rvalid0_q     <= 1'b0;
      rvalid1_q     <= 1'b0;
      err0_q        <= 1'b0;
      err1_q        <= 1'b0;
      rdata0_q      <= 32'h0;
      rdata1_q      <= 32'h0;
`ifdef DMEM_ARB_RR_EN
      prio_q        <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      req_we_q      <= req_we_d;
      req_id_q      <= req_id_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_wr_q <= mem_data_wr_d;
      mem_type_q    <= mem_type_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      rvalid0_q     <= rvalid0_d;
      rvalid1_q     <= rvalid1_d;
      err0_q        <= err0_d;
      err1_q        <= err1_d;
      rdata0_q      <= rdata0_d;
      rdata1_q      <= rdata1_d;
`ifdef DMEM_ARB_RR_EN
      prio_q        <= prio_d;
`endif
    end
  end

  assign mem_addr_o    = mem_addr_q;
  assign mem_data_wr_o = mem_data_wr_q;
  assign mem_type_o    = mem_type_q;
  assign mem_read_o    = mem_read_q;
  assign mem_write_o   = mem_write_q;
  assign req0_rvalid_o = rvalid0_q;
  assign req1_rvalid_o = rvalid1_q;
  assign req0_err_o    = err0_q;
  assign req1_err_o    = err1_q;
  assign req0_rdata_o  = rdata0_q;
  assign req1_rdata_o  = rdata1_q;

endmodule
